// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helpers for the slot scheduler.
package johnson_pkg;

   // Scheduler control states
   typedef enum logic [0:0] {
      SCAN  = 1'b0,
      GRANT = 1'b1
   } sched_state_t;

   // Number of set bits among the low 'width' bits of a Johnson code
   function automatic int unsigned jc_ones(input logic [31:0] code,
                                           input int unsigned width);
      int unsigned ones;
      ones = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((i < width) && code[i]) begin
            ones++;
         end
      end
      return ones;
   endfunction

   // Johnson code to slot index: ones fill from the top first, then drain from the top
   function automatic int unsigned jc_decode(input logic [31:0] code,
                                             input int unsigned width);
      int unsigned ones;
      ones = jc_ones(code, width);
      if (code[0] == 1'b0) begin
         return ones;
      end
      return (2 * width) - ones;
   endfunction

   // A legal Johnson code has at most one boundary between adjacent differing bits
   function automatic logic jc_legal(input logic [31:0] code,
                                     input int unsigned width);
      int unsigned edges;
      edges = 0;
      for (int unsigned i = 0; i < 31; i++) begin
         if (((i + 1) < width) && (code[i] != code[i+1])) begin
            edges++;
         end
      end
      return (edges <= 32'd1);
   endfunction

endpackage

// File: rtl/johnson_step_ctr.sv
// Johnson counter register with step enable and synchronous clear.
module johnson_step_ctr #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   // Clear wins over step; the register advances one Johnson position per step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (step) begin
         q <= {~q[0], q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/johnson_slot_sched.sv
// Johnson-counter time-slot scheduler: visits 2*WIDTH slots in fixed order,
// grants the current slot owner for at most HOLD cycles per visit.
// Optional illegal-phase checker: define JOHNSON_SLOT_SCHED_ERR_CHK_EN.
module johnson_slot_sched #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned HOLD  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [2*WIDTH-1:0]            req,
   output logic [2*WIDTH-1:0]            gnt,
   output logic                          gnt_vld,
   output logic [$clog2(2*WIDTH)-1:0]    gnt_id,
   output logic [WIDTH-1:0]              phase,
   output logic                          err
);

   import johnson_pkg::*;

   localparam int unsigned NREQ = 2 * WIDTH;
   localparam int unsigned SW   = $clog2(NREQ);
   localparam int unsigned HW   = (HOLD > 1) ? $clog2(HOLD) : 1;

   sched_state_t    state_q;
   sched_state_t    state_d;
   logic [HW-1:0]   hold_q;
   logic [HW-1:0]   hold_d;
   logic [NREQ-1:0] gnt_d;
   logic            gnt_vld_d;
   logic [SW-1:0]   gnt_id_d;

   logic            step_c;
   logic            clr_c;
   logic            illegal_c;
   logic            req_cur_c;
   logic            hold_last_c;
   logic [SW-1:0]   slot_c;

   // Johnson register holding the slot position
   johnson_step_ctr #(
      .WIDTH (WIDTH)
   ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (step_c),
      .clr   (clr_c),
      .q     (phase)
   );

   // Slot currently owning the time slot and its request level
   assign slot_c      = SW'(jc_decode(32'(phase), WIDTH));
   assign req_cur_c   = req[slot_c];
   assign hold_last_c = (hold_q == HW'(HOLD - 1));

`ifdef JOHNSON_SLOT_SCHED_ERR_CHK_EN
   logic err_q;

   assign illegal_c = !jc_legal(32'(phase), WIDTH);
   assign err       = err_q;

   // Sticky illegal-phase flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (illegal_c) begin
         err_q <= 1'b1;
      end
   end
`else
   assign illegal_c = 1'b0;
   assign err       = 1'b0;
`endif

   // Next-state, slot-step and next-grant decision
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      gnt_d     = '0;
      gnt_vld_d = 1'b0;
      gnt_id_d  = '0;
      step_c    = 1'b0;
      clr_c     = 1'b0;

      if (illegal_c) begin
         // Recover to slot 0 with no grant
         clr_c   = 1'b1;
         state_d = SCAN;
         hold_d  = '0;
      end else begin
         case (state_q)
            SCAN: begin
               if (en) begin
                  if (req_cur_c) begin
                     state_d   = GRANT;
                     hold_d    = '0;
                     gnt_d     = NREQ'(1) << slot_c;
                     gnt_vld_d = 1'b1;
                     gnt_id_d  = slot_c;
                  end else begin
                     step_c = 1'b1;
                  end
               end
            end
            GRANT: begin
               if (!en) begin
                  // Disable keeps the slot position so the owner resumes first
                  state_d = SCAN;
                  hold_d  = '0;
               end else if (!req_cur_c || hold_last_c) begin
                  state_d = SCAN;
                  hold_d  = '0;
                  step_c  = 1'b1;
               end else begin
                  hold_d    = hold_q + HW'(1);
                  gnt_d     = NREQ'(1) << slot_c;
                  gnt_vld_d = 1'b1;
                  gnt_id_d  = slot_c;
               end
            end
            default: begin
               state_d = SCAN;
               hold_d  = '0;
            end
         endcase
      end
   end

   // State, hold counter and registered grant outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SCAN;
         hold_q  <= '0;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         gnt_id  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gnt     <= gnt_d;
         gnt_vld <= gnt_vld_d;
         gnt_id  <= gnt_id_d;
      end
   end

endmodule

// File: tb/tb_johnson_slot_sched.sv
// Directed self-checking bench for johnson_slot_sched (WIDTH=4, HOLD=4).
module tb_johnson_slot_sched;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned HOLD  = 4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic       gnt_vld;
   logic [2:0] gnt_id;
   logic [3:0] phase;
   logic       err;

   logic [16:0] obs;
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   localparam logic [3:0] JSEQ [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                       4'b0111, 4'b0011, 4'b0001, 4'b0000};

   johnson_slot_sched #(
      .WIDTH (WIDTH),
      .HOLD  (HOLD)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id),
      .phase   (phase),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {gnt, gnt_vld, gnt_id, phase, err};

   // Packs an expected output tuple in the same layout as obs
   function automatic logic [16:0] exp_v(input logic [7:0] g, input logic [2:0] id,
                                         input logic [3:0] ph, input logic er);
      return {g, |g, id, ph, er};
   endfunction

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic test_reset;
      logic [16:0] e;
      rst_n = 1'b0; en = 1'b0; req = 8'h00;
      tick(); tick();
      e = exp_v(8'h00, 3'd0, 4'b0000, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL reset: got %h want %h", obs, e);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_skip;
      logic [16:0] e;
      en = 1'b1; req = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tick();
         e = exp_v(8'h00, 3'd0, JSEQ[i], 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL skip step%0d: got %h want %h", i, obs, e);
         else n_pass++;
      end
      // Disabled: no step and no grant even with the current slot requesting
      en = 1'b0; req = 8'h01;
      for (int i = 0; i < 2; i++) begin
         tick();
         e = exp_v(8'h00, 3'd0, 4'b0000, 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL en_freeze c%0d: got %h want %h", i, obs, e);
         else n_pass++;
      end
   endtask

   task automatic test_bounded_grant;
      logic [16:0] e;
      en = 1'b1; req = 8'h01;
      for (int i = 0; i < 4; i++) begin
         tick();
         e = exp_v(8'h01, 3'd0, 4'b0000, 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL hold_grant c%0d: got %h want %h", i, obs, e);
         else n_pass++;
      end
      tick();
      e = exp_v(8'h00, 3'd0, 4'b1000, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL hold_release: got %h want %h", obs, e);
      else n_pass++;
      req = 8'h00;
      tick();
      e = exp_v(8'h00, 3'd0, 4'b1100, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL slot1_skip: got %h want %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_early_release;
      logic [16:0] e;
      req = 8'h04;
      for (int i = 0; i < 3; i++) begin
         tick();
         e = exp_v(8'h04, 3'd2, 4'b1100, 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL early_grant c%0d: got %h want %h", i, obs, e);
         else n_pass++;
      end
      req = 8'h00;
      tick();
      e = exp_v(8'h00, 3'd0, 4'b1110, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL early_release: got %h want %h", obs, e);
      else n_pass++;
      tick();
      tick();
      e = exp_v(8'h00, 3'd0, 4'b0111, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL walk_to_slot5: got %h want %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_enable_drop;
      logic [16:0] e;
      req = 8'h20;
      for (int i = 0; i < 2; i++) begin
         tick();
         e = exp_v(8'h20, 3'd5, 4'b0111, 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL slot5_grant c%0d: got %h want %h", i, obs, e);
         else n_pass++;
      end
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         e = exp_v(8'h00, 3'd0, 4'b0111, 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL en_drop c%0d: got %h want %h", i, obs, e);
         else n_pass++;
      end
      en = 1'b1;
      tick();
      e = exp_v(8'h20, 3'd5, 4'b0111, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL regrant: got %h want %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_reset_mid_grant;
      logic [16:0] e;
      tick();
      e = exp_v(8'h20, 3'd5, 4'b0111, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL pre_reset_grant: got %h want %h", obs, e);
      else n_pass++;
      rst_n = 1'b0;
      tick();
      e = exp_v(8'h00, 3'd0, 4'b0000, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL reset_mid_grant: got %h want %h", obs, e);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back;
      logic [16:0] e;
      en = 1'b1; req = 8'h80;
      for (int i = 0; i < 7; i++) begin
         tick();
         e = exp_v(8'h00, 3'd0, JSEQ[i], 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL nc_ignore step%0d: got %h want %h", i, obs, e);
         else n_pass++;
      end
      tick();
      req = 8'h81;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         e = exp_v(8'h80, 3'd7, 4'b0001, 1'b0);
         n_total++;
         if (obs !== e) $display("FAIL slot7_grant c%0d: got %h want %h", i, obs, e);
         else n_pass++;
      end
      tick();
      e = exp_v(8'h00, 3'd0, 4'b0000, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL wrap: got %h want %h", obs, e);
      else n_pass++;
      tick();
      e = exp_v(8'h01, 3'd0, 4'b0000, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL slot0_after_wrap: got %h want %h", obs, e);
      else n_pass++;
      req = 8'h00;
      tick();
      e = exp_v(8'h00, 3'd0, 4'b1000, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL slot0_release: got %h want %h", obs, e);
      else n_pass++;
   endtask

`ifdef JOHNSON_SLOT_SCHED_ERR_CHK_EN
   task automatic test_err_check;
      logic [16:0] e;
      en = 1'b0; req = 8'h00;
      force dut.u_ctr.q = 4'b0101;
      #1;
      release dut.u_ctr.q;
      tick();
      e = exp_v(8'h00, 3'd0, 4'b0000, 1'b1);
      n_total++;
      if (obs !== e) $display("FAIL err_set: got %h want %h", obs, e);
      else n_pass++;
      en = 1'b1;
      tick();
      e = exp_v(8'h00, 3'd0, 4'b1000, 1'b1);
      n_total++;
      if (obs !== e) $display("FAIL err_sticky: got %h want %h", obs, e);
      else n_pass++;
      rst_n = 1'b0;
      tick();
      e = exp_v(8'h00, 3'd0, 4'b0000, 1'b0);
      n_total++;
      if (obs !== e) $display("FAIL err_reset: got %h want %h", obs, e);
      else n_pass++;
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_skip();
      test_bounded_grant();
      test_early_release();
      test_enable_drop();
      test_reset_mid_grant();
      test_back_to_back();
`ifdef JOHNSON_SLOT_SCHED_ERR_CHK_EN
      test_err_check();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
